// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART receive path
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - loadable down-counter with zero flag for bit timing
module uart_baud_cnt #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  // Load has priority; otherwise count down and park at zero rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/uart_cmd_rcv.sv
// rtl/uart_cmd_rcv.sv - 8N1 command-link receiver with ready/clear handshake
module uart_cmd_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err,
  output logic       busy
);

  localparam int              CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]   FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);

  rx_state_t                state;
  rx_state_t                state_nxt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rx_s;
  logic [3:0]               bit_cnt;
  logic [DATA_BITS-1:0]     shreg;
  logic                     expire;
  logic                     cnt_load;
  logic [CW-1:0]            cnt_load_val;
  logic                     shift_en;
  logic                     bit_clr;
  logic                     done_set;
  logic                     frm_set;
  logic                     done;

  // Synchronizer presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_baud_cnt #(
    .WIDTH(CW)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .expire  (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle controls; sampling happens whenever the baud counter hits zero.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = FULL_LOAD;
    shift_en     = 1'b0;
    bit_clr      = 1'b0;
    done_set     = 1'b0;
    frm_set      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_load     = 1'b1;
          cnt_load_val = HALF_LOAD;
          state_nxt    = START;
        end
      end
      START: begin
        if (expire) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            cnt_load  = 1'b1;
            bit_clr   = 1'b1;
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            frm_set   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mid-bit samples enter at the top so the first received bit ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

  // Byte hand-off one cycle after a good stop bit; a simultaneous clear loses to the set
  // and counts as an acknowledge, so it suppresses the overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      done    <= done_set;
      frm_err <= frm_set;
      ovr_err <= done & rdy & ~clr_rdy;
      if (done) begin
        rx_data <= shreg;
        rdy     <= 1'b1;
      end else if (clr_rdy) begin
        rdy <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// tb/tb_uart_cmd_rcv.sv - directed self-checking bench for uart_cmd_rcv
module tb_uart_cmd_rcv;

  localparam int B       = 64;
  // Two sync flops plus the IDLE sampling edge add 3 clocks ahead of the frame latency.
  localparam int EXP_LAT = (B / 2) + 9 * B + 1 + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int frm_cnt = 0;
  int ovr_cnt = 0;
  int both_cnt = 0;
  logic rdy_q = 1'b0;

  uart_cmd_rcv #(
    .BAUD_DIV   (B),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .RX     (rx_line),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .ovr_err(ovr_err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_cnt++;
    if (ovr_err) ovr_cnt++;
    if (frm_err && ovr_err) both_cnt++;
    if (rdy && !rdy_q) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    rdy_q = rdy;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    rx_line = 1'b0;
    start_cyc = cyc;
    repeat (B) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (B) @(posedge clk); #1;
    end
    rx_line = stop;
    repeat (B) @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
    n_cmp++; if (frm_err !== 1'b0) begin n_bad++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    n_cmp++; if (ovr_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovr_err: got %b want 0", ovr_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single();
    int f0, o0;
    f0 = frm_cnt; o0 = ovr_cnt;
    send_byte(8'h47, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rise_cyc - start_cyc !== EXP_LAT) begin n_bad++; $display("FAIL single_latency: got %0d want %0d", rise_cyc - start_cyc, EXP_LAT); end
    n_cmp++; if (rx_data !== 8'h47) begin n_bad++; $display("FAIL single_data: got %h want 47", rx_data); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL single_rdy: got %b want 1", rdy); end
    n_cmp++; if (frm_cnt - f0 !== 0) begin n_bad++; $display("FAIL single_frm: got %0d pulses want 0", frm_cnt - f0); end
    n_cmp++; if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL single_ovr: got %0d pulses want 0", ovr_cnt - o0); end
    pulse_clr();
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL single_clr: got %b want 0", rdy); end
  endtask

  task automatic test_back_to_back();
    int f0, o0, r0;
    f0 = frm_cnt; o0 = ovr_cnt; r0 = rise_cnt;
    send_byte(8'h53, 1'b1);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h53) begin n_bad++; $display("FAIL b2b_first: got %h want 53", rx_data); end
    pulse_clr();
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_clr: got %b want 0", rdy); end
    send_byte(8'h47, 1'b1);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h47) begin n_bad++; $display("FAIL b2b_second: got %h want 47", rx_data); end
    n_cmp++; if (rise_cnt - r0 !== 2) begin n_bad++; $display("FAIL b2b_rises: got %0d want 2", rise_cnt - r0); end
    n_cmp++; if ((frm_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_bad++; $display("FAIL b2b_errors: got %0d want 0", (frm_cnt - f0) + (ovr_cnt - o0)); end
    pulse_clr();
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_clr2: got %b want 0", rdy); end
  endtask

  task automatic test_glitch();
    int f0, r0;
    f0 = frm_cnt; r0 = rise_cnt;
    @(posedge clk); #1;
    rx_line = 1'b0;
    repeat (12) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi: got %b want 1", busy); end
    rx_line = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo: got %b want 0", busy); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
    n_cmp++; if (rx_data !== 8'h47) begin n_bad++; $display("FAIL glitch_data: got %h want 47", rx_data); end
    n_cmp++; if (frm_cnt - f0 !== 0) begin n_bad++; $display("FAIL glitch_frm: got %0d want 0", frm_cnt - f0); end
    n_cmp++; if (rise_cnt - r0 !== 0) begin n_bad++; $display("FAIL glitch_rise: got %0d want 0", rise_cnt - r0); end
  endtask

  task automatic test_framing();
    int f0, o0;
    f0 = frm_cnt; o0 = ovr_cnt;
    send_byte(8'hA5, 1'b0);
    repeat (3 * B) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (frm_cnt - f0 !== 1) begin n_bad++; $display("FAIL frm_pulses: got %0d want 1", frm_cnt - f0); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL frm_rdy: got %b want 0", rdy); end
    n_cmp++; if (rx_data !== 8'h47) begin n_bad++; $display("FAIL frm_data_kept: got %h want 47", rx_data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL frm_busy_held: got %b want 1", busy); end
    @(posedge clk); #1;
    rx_line = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL frm_busy_release: got %b want 0", busy); end
    send_byte(8'h3C, 1'b1);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL frm_next_data: got %h want 3c", rx_data); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL frm_next_rdy: got %b want 1", rdy); end
    n_cmp++; if ((frm_cnt - f0 !== 1) || (ovr_cnt - o0 !== 0)) begin n_bad++; $display("FAIL frm_err_totals: got frm %0d ovr %0d want 1 0", frm_cnt - f0, ovr_cnt - o0); end
    pulse_clr();
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    send_byte(8'h11, 1'b1);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_first: got %h want 11", rx_data); end
    send_byte(8'h22, 1'b1);
    @(negedge clk);
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt - o0); end
    n_cmp++; if (rx_data !== 8'h22) begin n_bad++; $display("FAIL ovr_data: got %h want 22", rx_data); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL ovr_rdy: got %b want 1", rdy); end
    fork
      send_byte(8'h33, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (EXP_LAT - 1) @(posedge clk); #1;
        clr_rdy = 1'b1;
        @(posedge clk); #1;
        clr_rdy = 1'b0;
      end
    join
    @(negedge clk);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL coll_rdy: got %b want 1", rdy); end
    n_cmp++; if (rx_data !== 8'h33) begin n_bad++; $display("FAIL coll_data: got %h want 33", rx_data); end
    n_cmp++; if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL coll_ovr: got %0d pulses want 1", ovr_cnt - o0); end
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    int f0, o0, r0;
    logic busy_seen;
    f0 = frm_cnt; o0 = ovr_cnt; r0 = rise_cnt;
    busy_seen = 1'b0;
    fork
      send_byte(8'h5A, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (340) @(posedge clk); #1;
        busy_seen = busy;
        rst = 1'b1;
      end
    join
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy_seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy_seen); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy: got %b want 0", rdy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
    n_cmp++; if (rise_cnt - r0 !== 0) begin n_bad++; $display("FAIL rstmid_rise: got %0d want 0", rise_cnt - r0); end
    n_cmp++; if ((frm_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_bad++; $display("FAIL rstmid_errors: got %0d want 0", (frm_cnt - f0) + (ovr_cnt - o0)); end
    send_byte(8'h69, 1'b1);
    @(negedge clk);
    n_cmp++; if (rx_data !== 8'h69) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 69", rx_data); end
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_rdy: got %b want 1", rdy); end
    n_cmp++; if ((frm_cnt - f0) + (ovr_cnt - o0) !== 0) begin n_bad++; $display("FAIL rstmid_next_errors: got %0d want 0", (frm_cnt - f0) + (ovr_cnt - o0)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL err_exclusive: got %0d overlaps want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rcv.md
Name: uart_cmd_rcv

Overview:
- 8N1 UART receiver that is the receive end of the command link into the Segway.
- Accepts serial bytes on RX, the line driven by the BLE module or by the bench-side UART_tx, and presents each byte with a ready/clear handshake to the command-processing logic.
- Detects false starts, framing errors and overruns.
- Sits at the top of Segway, directly behind the RX pin.

Parameters:
- BAUD_DIV, 2604: clocks per bit. Gives 19200 baud at 50 MHz and must match UART_tx.
- SYNC_STAGES, 2: metastability flops on RX. Legal range 2..3.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial input; idles high; asynchronous to clk.
- clr_rdy  in  1  consumer acknowledge; clears rdy.
- rx_data  out  8  last correctly framed byte.
- rdy  out  1  a byte is available; held until cleared.
- frm_err  out  1  one-cycle pulse: stop bit sampled low.
- ovr_err  out  1  one-cycle pulse: a new byte completed while rdy was still 1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Synchronizer flops preset to 1, so no false start comes out of reset.
  - rx_data=0x00, rdy=0, frm_err=0, ovr_err=0, busy=0.
  - State=IDLE, bit counter=0, baud counter=0.
- Reset asserted mid-frame aborts the frame immediately. No rdy and no error pulse are produced.
- RX passes through SYNC_STAGES flops. All decisions use the synchronized value rx_s.
- States:
  - IDLE: on the first cycle rx_s==0, load baud_cnt=BAUD_DIV/2-1 and go to START.
  - START: when baud_cnt reaches 0, sample rx_s.
    - rx_s==1: false start; return to IDLE, no outputs change.
    - rx_s==0: load baud_cnt=BAUD_DIV-1, clear bit_cnt, go to DATA.
  - DATA: at each baud_cnt==0, shift rx_s into a shift register LSB-first, increment bit_cnt and reload baud_cnt. After the 8th sample, go to STOP.
  - STOP: at baud_cnt==0, sample rx_s.
    - rx_s==1: on the next clock edge, rx_data<=shift register and rdy<=1. Return to IDLE.
    - rx_s==0: frm_err pulses for 1 cycle; rx_data and rdy are unchanged; go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line never produces bytes.
- Sampling points fall at the middle of each bit.
  - Latency from the synchronized start edge to rdy rising: (BAUD_DIV/2) + 9*BAUD_DIV + 1 clocks.
- Overrun: the STOP state samples 1 while rdy==1.
  - rx_data is overwritten with the new byte.
  - rdy stays 1.
  - ovr_err pulses for 1 cycle.
- Handshake:
  - rdy is cleared only by clr_rdy (sampled at posedge).
  - If clr_rdy and a new-byte set occur in the same cycle, the set wins: rdy=1, with no ovr_err.
- Counter widths:
  - baud_cnt is $clog2(BAUD_DIV) bits, down-counting, and never wraps: it reloads at 0.
  - bit_cnt is 4 bits.
- frm_err and ovr_err are registered and never asserted together.

Decomposition:
- Package uart_pkg holds:
  - localparam BAUD_DIV_DEFAULT=2604.
  - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t.
  - localparam DATA_BITS=8.
- Sub-module uart_baud_cnt: loadable down-counter with a zero flag (inputs load, load_val; output expire). It is reused by the transmit side.
- Synchronizer and shift register stay inline.

Test Plan:
- Single byte: UART_tx sends 0x47 ('G') at BAUD_DIV=2604.
  - Required: rdy rises exactly (1302+9*2604+1) clocks after the synchronized start edge, plus synchronizer latency.
  - Required: rx_data=0x47, frm_err=0, ovr_err=0.
- Back-to-back bytes: send 0x53 then 0x47, pulsing clr_rdy after each.
  - Required: rx_data reads 0x53, then 0x47.
  - Required: rdy toggles 1→0→1 and no errors occur.
- Glitch: drive RX low for 500 clocks, then high.
  - Required: returns to IDLE, busy falls, and rdy, rx_data and frm_err are unchanged.
- Framing error: send 0xA5 with the stop bit forced 0, then hold RX low for 3*BAUD_DIV, then release.
  - Required: one frm_err pulse, rdy=0, rx_data unchanged, busy stays 1 until RX is released.
  - Required: a following 0x3C is received correctly.
- Overrun and collision:
  - Send 0x11, then 0x22 without clr_rdy. Required: ovr_err pulses once, rx_data=0x22, rdy=1.
  - Send 0x33 while asserting clr_rdy on the rdy-set cycle. Required: rdy=1, no ovr_err.
- Reset mid-frame: assert rst during data bit 4 of 0x5A, release it, then send 0x69.
  - Required: no rdy or error pulse for the aborted frame.
  - Required: rx_data=0x69 is received correctly.
